// File: rtl/nn_pkg.sv
// Shared fixed-point parameters and types for the layer datapath
// (address generator, MAC and activation stages).
package nn_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC   = 4;
  localparam int ACC_W  = 24;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  localparam int Q_ONE = 1 << FRAC;
  localparam int Q_MAX = (1 << (DATA_W - 1)) - 1;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    logic              vld;
    logic              first;
    logic              last;
    logic [ADDR_W-1:0] addr;
    prod_t             prod;
  } mul_stage_t;
endpackage

// File: rtl/relu_sat.sv
// Combinational Q-format rescale, ReLU and upper clamp from accumulator width
// down to a DATA_W result.
module relu_sat
  import nn_pkg::*;
(
  input  acc_t  acc_i,
  output data_t act_o
);
  localparam acc_t ACC_QMAX = acc_t'(Q_MAX);

  acc_t shifted;

  always_comb begin
    shifted = acc_i >>> FRAC;
    act_o   = '0;
    if (shifted < 0)
      act_o = '0;
    else if (shifted > ACC_QMAX)
      act_o = data_t'(Q_MAX);
    else
      act_o = shifted[DATA_W-1:0];
  end
endmodule

// File: rtl/neuron_mac.sv
// Three-stage multiply / accumulate / activate pipeline. Nk products are summed
// per neuron, then one saturated ReLU result is written to neuron RAM.
module neuron_mac
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         Nk,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] weight_data,
  input  logic signed [DATA_W-1:0] neuro_data,
  input  logic [ADDR_W-1:0]        neuro_write_addr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     err
);
  mul_stage_t        mul_q, mul_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nk_q, nk_d;
  logic              err_q, err_d;
  acc_t              acc_q, acc_d;
  logic              acc_vld_q;
  logic              pend_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  data_t             wr_data_q;

  prod_t             w_ext, n_ext, mprod;
  logic [CNT_W-1:0]  cnt_inc, nk_eff;
  data_t             act;

  // Widen before multiplying so the full signed product is kept.
  assign w_ext = prod_t'(weight_data);
  assign n_ext = prod_t'(neuro_data);
  assign mprod = mul_q.prod;

  assign cnt_inc = cnt_q + 1'b1;
  assign nk_eff  = first_q ? Nk : nk_q;

  always_comb begin
    mul_d       = mul_q;
    mul_d.vld   = in_valid;
    first_d     = first_q;
    cnt_d       = cnt_q;
    nk_d        = nk_q;
    err_d       = err_q;
    if (in_valid) begin
      mul_d.prod  = w_ext * n_ext;
      mul_d.first = first_q;
      mul_d.last  = in_last;
      mul_d.addr  = neuro_write_addr;
      first_d     = in_last;
      cnt_d       = in_last ? '0 : cnt_inc;
      nk_d        = nk_eff;
      if (in_last && (cnt_inc != nk_eff))
        err_d = 1'b1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (mul_q.vld)
      acc_d = mul_q.first ? acc_t'(mprod) : acc_q + acc_t'(mprod);
  end

  relu_sat u_relu_sat (
    .acc_i (acc_q),
    .act_o (act)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_q     <= '0;
      first_q   <= 1'b1;
      cnt_q     <= '0;
      nk_q      <= '0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      paddr_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      mul_q     <= mul_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      nk_q      <= nk_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      acc_vld_q <= mul_q.vld;
      pend_q    <= mul_q.vld & mul_q.last;
      if (mul_q.vld && mul_q.last)
        paddr_q <= mul_q.addr;
      // The output stage reads acc_q before the next neuron's first product
      // overwrites it, which is what allows back-to-back neurons.
      wr_en_q <= pend_q;
      if (pend_q) begin
        wr_addr_q <= paddr_q;
        wr_data_q <= act;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;
  assign busy    = mul_q.vld | acc_vld_q | pend_q | ~first_q;
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Accumulates neuron outputs in the layer datapath, directly downstream of the address generator. Each cycle the generator presents a weight/neuron read pair; this block takes the two RAM outputs, multiplies them and accumulates Nk products per neuron. It then applies a saturating ReLU and issues one write into neuron RAM at the address the generator supplied. It is fully pipelined, so back-to-back neurons need no bubble.

## Interface
- DATA_W, 8: signed fixed-point width of weights, neuron values and results.
- FRAC, 4: fractional bits of DATA_W values (Q3.4 by default).
- ACC_W, 24: accumulator width. Must be ≥ 2*DATA_W+8 so 255 full-scale products cannot overflow.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- Nk  in  8  inputs per neuron. Sampled on each pair that starts a neuron.
- in_valid  in  1  weight_data/neuro_data hold a valid pair this cycle (RAM read latency already aligned upstream).
- in_last  in  1  qualifies in_valid: this pair is the neuron's final product.
- weight_data  in  DATA_W  signed weight.
- neuro_data  in  DATA_W  signed neuron input.
- neuro_write_addr  in  8  destination address. Sampled with the in_last pair.
- wr_en  out  1  one-cycle write strobe to neuron RAM.
- wr_addr  out  8  write address.
- wr_data  out  DATA_W  activated result.
- busy  out  1  a pair is in the pipeline or a neuron is partially accumulated.
- err  out  1  sticky: the pair count of a neuron did not equal Nk.

## Operation
- Stage 1 (MUL): on in_valid, register prod = weight_data*neuro_data (2*DATA_W signed). Alongside it, register last and addr, plus a `first` flag that marks the opening pair of a neuron.
- Stage 2 (ACC): if first, acc ← sext(prod); otherwise acc ← acc + sext(prod). If last, also register addr for output and raise the out_pending flag.
- Stage 3 (OUT): when out_pending is set:
  - s = acc >>> FRAC (arithmetic shift, rounds toward −inf);
  - wr_data = 0 if s < 0; 2^(DATA_W−1)−1 if s > that value; s otherwise;
  - wr_en = 1 for exactly one cycle.
- No FSM states beyond the per-stage valid bits and the `first` flag. `first` is 1 after reset and after each last pair, and 0 after any other valid pair.
- Pair counter, 8 bits:
  - resets to 0 after each last pair;
  - increments on every valid pair;
  - on a last pair, if count+1 ≠ Nk (Nk latched at the first pair), set err. err clears only on reset.
  - Nk = 0: any neuron sets err; the neuron is still written.
- in_last without in_valid is ignored. in_valid cycles with in_valid low between them are allowed and simply stall accumulation.
- A single-pair neuron (first and last together) is legal.
- busy = MUL valid | ACC valid | out_pending | ~first.

## Timing
- Pair presented in cycle c gives prod in c+1 and acc in c+2. If it is last, wr_en/wr_addr/wr_data are valid in cycle c+3.
- Throughput: one pair per cycle, including the first pair of the next neuron in cycle c+1 after a last pair.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, err 0, acc 0, first 1, counter 0.
- Reset mid-neuron discards partial sums and in-flight writes; no wr_en is issued for that neuron.

## Structure
- Shared package nn_pkg holds DATA_W, FRAC, ACC_W and the Q-format constants; the address generator uses the same package.
- One sub-module, relu_sat: combinational shift, clamp and ReLU from ACC_W to DATA_W. It is reused by any later activation stage.

## Test plan
- Nk=3; weights 16,16,16 with neuro 16,32,48 (1.0 × 1,2,3); last on the third pair, addr 0x05 → wr_en 3 cycles after the last pair, wr_addr 0x05, wr_data 96, err 0.
- Nk=2; weights 16,16 with neuro −32,−16 → wr_data 0 (ReLU).
- Nk=2; both pairs 127×127 → sum 32258 >>> 4 = 2016 → wr_data 127 (saturated).
- Two neurons back-to-back with Nk=1: pairs (16,16) to addr 1, then (32,16) to addr 2 in consecutive cycles → writes 16 then 32 in consecutive cycles, no bubble.
- Nk=4 with last on the third pair → write still issued, err rises and stays 1 until reset.
- Reset asserted in the cycle after the second of three pairs, then a clean Nk=1 neuron (16,16) → no stray wr_en, then exactly one write of 16.
